// File: rtl/bip_data_mem_responder.sv
// bip_data_mem_responder
// Data-memory responder for the BIP I CPU. Replaces a plain RAM on the data bus.
// The low addresses are a word-addressed RAM. A small memory-mapped I/O window
// sits at IO_BASE and holds five registers:
//   +0 OUT     read/write, drives Out_Port
//   +1 IN_DATA read-only, returns the input latch; a read clears the input flag
//   +2 IN_STAT read-only, bit0 = input flag
//   +3 CYC     cycle counter; a write clears it
//   +4 WCNT    read-only, saturating count of accepted writes
// Ports:
//   Clock, Reset (synchronous, active-low)
//   Rd, Wr, DataAddr, In_Data -> Out_Data (combinational, zero latency)
//   Out_Port                  registered output port
//   Ext_Data/Ext_Valid/Ext_Ready  input port handshake
//   Err                       sticky flag for accesses to unmapped addresses
module bip_data_mem_responder #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 11,
  parameter int                RAM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] IO_BASE   = 'h7F0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] In_Data,
  output logic [DATA_W-1:0] Out_Data,
  output logic [DATA_W-1:0] Out_Port,
  input  logic [DATA_W-1:0] Ext_Data,
  input  logic              Ext_Valid,
  output logic              Ext_Ready,
  output logic              Err
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] in_latch;
  logic              in_flag;
  logic [DATA_W-1:0] cyc_cnt;
  logic [DATA_W-1:0] wr_cnt;

  logic              is_ram, is_out, is_in_data, is_in_stat, is_cyc, is_wcnt;
  logic              is_mapped;
  logic [RAM_AW-1:0] ram_idx;

  assign is_ram     = (DataAddr < ADDR_W'(RAM_DEPTH));
  assign is_out     = (DataAddr == IO_BASE);
  assign is_in_data = (DataAddr == IO_BASE + ADDR_W'(1));
  assign is_in_stat = (DataAddr == IO_BASE + ADDR_W'(2));
  assign is_cyc     = (DataAddr == IO_BASE + ADDR_W'(3));
  assign is_wcnt    = (DataAddr == IO_BASE + ADDR_W'(4));
  assign is_mapped  = is_ram | is_out | is_in_data | is_in_stat | is_cyc | is_wcnt;

  // Index only after the range check; out-of-range addresses never reach the RAM.
  assign ram_idx = DataAddr[RAM_AW-1:0];

  assign Ext_Ready = ~in_flag;

  // Zero-latency read; a same-cycle write still shows the pre-write value.
  always_comb begin
    Out_Data = '0;
    if (Rd) begin
      if (is_ram)          Out_Data = mem[ram_idx];
      else if (is_out)     Out_Data = Out_Port;
      else if (is_in_data) Out_Data = in_latch;
      else if (is_in_stat) Out_Data = {{(DATA_W-1){1'b0}}, in_flag};
      else if (is_cyc)     Out_Data = cyc_cnt;
      else if (is_wcnt)    Out_Data = wr_cnt;
    end
  end

  // RAM contents survive reset, but a write during reset is dropped.
  always_ff @(posedge Clock) begin
    if (Reset && Wr && is_ram) mem[ram_idx] <= In_Data;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Out_Port <= '0;
      in_latch <= '0;
      in_flag  <= 1'b0;
      cyc_cnt  <= '0;
      wr_cnt   <= '0;
      Err      <= 1'b0;
    end else begin
      if (Wr && is_cyc) cyc_cnt <= '0;
      else              cyc_cnt <= cyc_cnt + DATA_W'(1);

      if (Wr && is_out) Out_Port <= In_Data;

      // Only writes that change state are counted; read-only targets are not.
      if (Wr && (is_ram || is_out || is_cyc) && (wr_cnt != '1))
        wr_cnt <= wr_cnt + DATA_W'(1);

      if ((Rd || Wr) && !is_mapped) Err <= 1'b1;

      // A read-clear edge takes no new word: Ext_Ready was low during that cycle.
      if (in_flag) begin
        if (Rd && is_in_data) in_flag <= 1'b0;
      end else if (Ext_Valid) begin
        in_flag  <= 1'b1;
        in_latch <= Ext_Data;
      end
    end
  end

endmodule

// File: tb/tb_bip_data_mem_responder.sv
module tb_bip_data_mem_responder;

  localparam logic [10:0] IO_OUT  = 11'h7F0;
  localparam logic [10:0] IO_IN   = 11'h7F1;
  localparam logic [10:0] IO_STAT = 11'h7F2;
  localparam logic [10:0] IO_CYC  = 11'h7F3;
  localparam logic [10:0] IO_WCNT = 11'h7F4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Rd, Wr;
  logic [10:0] DataAddr;
  logic [15:0] In_Data;
  logic [15:0] Out_Data;
  logic [15:0] Out_Port;
  logic [15:0] Ext_Data;
  logic        Ext_Valid;
  logic        Ext_Ready;
  logic        Err;

  int n_cmp = 0;
  int n_bad = 0;

  bip_data_mem_responder dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Rd        (Rd),
    .Wr        (Wr),
    .DataAddr  (DataAddr),
    .In_Data   (In_Data),
    .Out_Data  (Out_Data),
    .Out_Port  (Out_Port),
    .Ext_Data  (Ext_Data),
    .Ext_Valid (Ext_Valid),
    .Ext_Ready (Ext_Ready),
    .Err       (Err)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Rd = 1'b0; Wr = 1'b0; DataAddr = '0; In_Data = '0;
  endtask

  // Combinational read in the current cycle (no edge taken).
  task automatic peek(input logic [10:0] a, input string tag, input logic [15:0] exp);
    Rd = 1'b1; Wr = 1'b0; DataAddr = a;
    #1;
    chk(tag, Out_Data, exp);
  endtask

  task automatic wr(input logic [10:0] a, input logic [15:0] d);
    Rd = 1'b0; Wr = 1'b1; DataAddr = a; In_Data = d;
    step();
    idle();
  endtask

  initial begin
    idle();
    Ext_Data = '0; Ext_Valid = 1'b0;

    // 1. Reset
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    #1;
    chk("rst_out_port", Out_Port, 16'h0000);
    chk("rst_ext_ready", {15'b0, Ext_Ready}, 16'h0001);
    chk("rst_err", {15'b0, Err}, 16'h0000);
    chk("rst_out_data_idle", Out_Data, 16'h0000);
    step();
    step();
    peek(IO_CYC, "cyc_after_2", 16'h0002);
    idle();

    // 2. RAM write/read and read-during-write
    wr(11'h005, 16'hBEEF);
    peek(11'h005, "ram_rd", 16'hBEEF);
    Wr = 1'b1; In_Data = 16'h1234;
    #1;
    chk("ram_rdwr_old", Out_Data, 16'hBEEF);
    step();
    peek(11'h005, "ram_rdwr_new", 16'h1234);
    peek(IO_WCNT, "wcnt_2", 16'h0002);
    idle();

    // 3. Input handshake
    Ext_Valid = 1'b1; Ext_Data = 16'h00A5;
    step();
    chk("in_ready_low", {15'b0, Ext_Ready}, 16'h0000);
    peek(IO_STAT, "in_stat_set", 16'h0001);
    Rd = 1'b0;
    Ext_Data = 16'h005A;
    step();
    chk("in_held_ready", {15'b0, Ext_Ready}, 16'h0000);
    peek(IO_IN, "in_data_a5", 16'h00A5);
    step();                       // read-clear edge; 0x5A not taken
    Rd = 1'b0;
    #1;
    chk("in_ready_back", {15'b0, Ext_Ready}, 16'h0001);
    peek(IO_IN, "in_latch_hold", 16'h00A5);
    Rd = 1'b0;
    step();
    chk("in_second_ready", {15'b0, Ext_Ready}, 16'h0000);
    peek(IO_IN, "in_data_5a", 16'h005A);
    Ext_Valid = 1'b0;
    step();                       // clears the flag
    idle();
    #1;
    chk("in_cleared", {15'b0, Ext_Ready}, 16'h0001);

    // 4. Output port and ignored read-only write
    wr(IO_OUT, 16'h0F0F);
    chk("out_port", Out_Port, 16'h0F0F);
    peek(IO_OUT, "out_rd", 16'h0F0F);
    wr(IO_IN, 16'hFFFF);
    chk("ro_wr_no_err", {15'b0, Err}, 16'h0000);
    peek(IO_WCNT, "wcnt_3", 16'h0003);
    peek(IO_IN, "ro_wr_latch", 16'h005A);
    idle();

    // 5. Unmapped access and sticky Err
    peek(11'h500, "unmapped_rd", 16'h0000);
    step();
    idle();
    #1;
    chk("err_set", {15'b0, Err}, 16'h0001);
    wr(11'h006, 16'h0001);
    chk("err_sticky", {15'b0, Err}, 16'h0001);
    peek(IO_WCNT, "wcnt_unmapped", 16'h0004);
    idle();
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    #1;
    chk("err_cleared", {15'b0, Err}, 16'h0000);
    chk("rst2_out_port", Out_Port, 16'h0000);

    // 6. Write during reset, CYC clear and wrap
    wr(11'h010, 16'h1111);
    Reset = 1'b0;
    Wr = 1'b1; DataAddr = 11'h010; In_Data = 16'h7777;
    step();
    Reset = 1'b1;
    idle();
    peek(11'h010, "ram_rst_wr", 16'h1111);
    peek(IO_WCNT, "wcnt_after_rst", 16'h0000);
    idle();
    wr(IO_CYC, 16'hABCD);         // clears to 0 at this edge
    peek(IO_CYC, "cyc_clear", 16'h0000);
    Rd = 1'b0;
    repeat (16'hFFFE) @(posedge Clock);
    #1;
    peek(IO_CYC, "cyc_fffe", 16'hFFFE);
    Wr = 1'b1; In_Data = 16'h5555;
    step();
    Wr = 1'b0;
    peek(IO_CYC, "cyc_wr_at_fffe", 16'h0000);
    step();
    peek(IO_CYC, "cyc_after_clear", 16'h0001);
    Rd = 1'b0;
    repeat (16'hFFFE) @(posedge Clock);
    #1;
    peek(IO_CYC, "cyc_ffff", 16'hFFFF);
    step();
    peek(IO_CYC, "cyc_wrap", 16'h0000);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
